// File: rtl/text_pkg.sv
// Shared character codes, writer states and grid index width helper for the text path.
package text_pkg;

    localparam logic [7:0] CHR_SP    = 8'h20;
    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_ESC   = 8'h1B;
    localparam logic [7:0] CHR_PRINT_MAX = 8'h7E;

    typedef enum logic [1:0] {IDLE, ESC, CLEAR} wr_state_e;

    // Index width for a grid dimension; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/text_writer_grid_cursor.sv
// Cursor (col,row) register pair with advance-with-wrap, CR, LF, decrement and zero.
// Latency: operations take effect at the next clk_pix edge; adv_* and at_last are combinational.
// Backpressure: none; callers assert at most one operation per cycle.
module grid_cursor
    import text_pkg::*;
#(
    parameter  int GRID_COL = 10,
    parameter  int GRID_ROW = 5,
    localparam int CW       = idx_width(GRID_COL),
    localparam int RW       = idx_width(GRID_ROW)
) (
    input  logic          clk_pix,
    input  logic          rst_n,
    input  logic          op_zero,
    input  logic          op_adv,
    input  logic          op_cr,
    input  logic          op_lf,
    input  logic          op_dec,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic [CW-1:0] adv_col,
    output logic [RW-1:0] adv_row,
    output logic          at_last
);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          col_end;
    logic          row_end;
    logic [RW-1:0] row_inc;

    assign col_end = (col_q == CW'(GRID_COL - 1));
    assign row_end = (row_q == RW'(GRID_ROW - 1));
    assign row_inc = row_end ? '0 : row_q + RW'(1);
    assign adv_col = col_end ? '0 : col_q + CW'(1);
    assign adv_row = col_end ? row_inc : row_q;
    assign at_last = col_end && row_end;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (op_zero) begin
            col_d = '0;
            row_d = '0;
        end else if (op_adv) begin
            col_d = adv_col;
            row_d = adv_row;
        end else if (op_cr) begin
            col_d = '0;
        end else if (op_lf) begin
            row_d = row_inc;
        end else if (op_dec) begin
            col_d = col_q - CW'(1);
        end
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col = col_q;
    assign row = row_q;

endmodule

// File: rtl/text_writer.sv
// Byte stream to character-cell writer: control codes, cursor, colour escape, screen clear.
// Latency: a byte accepted at edge N shows its cell write (and new cursor) in cycle N+1.
// Backpressure: in_ready drops only while CLEAR sweeps the grid; otherwise 1 byte/cycle.
module text_writer
    import text_pkg::*;
#(
    parameter  int                     GRID_ROW    = 5,
    parameter  int                     GRID_COL    = 10,
    parameter  int                     ASCII_WIDTH = 8,
    parameter  int                     COLOR_WIDTH = 4,
    parameter  logic [COLOR_WIDTH-1:0] DEFAULT_FG  = 4'hF,
    parameter  logic [COLOR_WIDTH-1:0] DEFAULT_BG  = 4'h0,
    localparam int                     CW          = idx_width(GRID_COL),
    localparam int                     RW          = idx_width(GRID_ROW)
) (
    input  logic                   clk_pix,
    input  logic                   rst_n,
    input  logic [ASCII_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   wr_en,
    output logic [CW-1:0]          wr_col,
    output logic [RW-1:0]          wr_row,
    output logic [ASCII_WIDTH-1:0] wr_char,
    output logic [COLOR_WIDTH-1:0] wr_fg,
    output logic [COLOR_WIDTH-1:0] wr_bg,
    output logic [CW-1:0]          cur_col,
    output logic [RW-1:0]          cur_row,
    output logic                   busy
);

    wr_state_e              state_q, state_d;
    logic [COLOR_WIDTH-1:0] fg_q, fg_d, bg_q, bg_d;
    logic                   wr_en_q, wr_en_d;
    logic [CW-1:0]          wr_col_q, wr_col_d;
    logic [RW-1:0]          wr_row_q, wr_row_d;
    logic [ASCII_WIDTH-1:0] wr_char_q, wr_char_d;
    logic [COLOR_WIDTH-1:0] wr_fg_q, wr_fg_d, wr_bg_q, wr_bg_d;

    logic          op_zero, op_adv, op_cr, op_lf, op_dec;
    logic [CW-1:0] adv_col;
    logic [RW-1:0] adv_row;
    logic          at_last;

    // Doubles as the CLEAR sweep counter, so cur_* tracks the sweep during a clear.
    grid_cursor #(
        .GRID_COL (GRID_COL),
        .GRID_ROW (GRID_ROW)
    ) u_cursor (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .op_zero (op_zero),
        .op_adv  (op_adv),
        .op_cr   (op_cr),
        .op_lf   (op_lf),
        .op_dec  (op_dec),
        .col     (cur_col),
        .row     (cur_row),
        .adv_col (adv_col),
        .adv_row (adv_row),
        .at_last (at_last)
    );

    always_comb begin
        state_d   = state_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        wr_en_d   = 1'b0;
        wr_col_d  = wr_col_q;
        wr_row_d  = wr_row_q;
        wr_char_d = wr_char_q;
        wr_fg_d   = wr_fg_q;
        wr_bg_d   = wr_bg_q;
        op_zero   = 1'b0;
        op_adv    = 1'b0;
        op_cr     = 1'b0;
        op_lf     = 1'b0;
        op_dec    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= CHR_SP && in_data <= CHR_PRINT_MAX) begin
                        wr_en_d   = 1'b1;
                        wr_col_d  = cur_col;
                        wr_row_d  = cur_row;
                        wr_char_d = in_data;
                        wr_fg_d   = fg_q;
                        wr_bg_d   = bg_q;
                        op_adv    = 1'b1;
                    end else if (in_data == CHR_CR) begin
                        op_cr = 1'b1;
                    end else if (in_data == CHR_LF) begin
                        op_lf = 1'b1;
                    end else if (in_data == CHR_BS) begin
                        if (cur_col != '0) begin
                            wr_en_d   = 1'b1;
                            wr_col_d  = cur_col - CW'(1);
                            wr_row_d  = cur_row;
                            wr_char_d = CHR_SP;
                            wr_fg_d   = fg_q;
                            wr_bg_d   = bg_q;
                            op_dec    = 1'b1;
                        end
                    end else if (in_data == CHR_FF) begin
                        // First clear write issues here so the sweep starts with no bubble.
                        state_d   = CLEAR;
                        wr_en_d   = 1'b1;
                        wr_col_d  = '0;
                        wr_row_d  = '0;
                        wr_char_d = CHR_SP;
                        wr_fg_d   = fg_q;
                        wr_bg_d   = bg_q;
                        op_zero   = 1'b1;
                    end else if (in_data == CHR_ESC) begin
                        state_d = ESC;
                    end
                end
            end
            ESC: begin
                if (in_valid) begin
                    fg_d    = in_data[COLOR_WIDTH-1:0];
                    bg_d    = in_data[4 +: COLOR_WIDTH];
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (at_last) begin
                    op_zero = 1'b1;
                    state_d = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_col_d  = adv_col;
                    wr_row_d  = adv_row;
                    wr_char_d = CHR_SP;
                    wr_fg_d   = fg_q;
                    wr_bg_d   = bg_q;
                    op_adv    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            fg_q      <= DEFAULT_FG;
            bg_q      <= DEFAULT_BG;
            wr_en_q   <= 1'b0;
            wr_col_q  <= '0;
            wr_row_q  <= '0;
            wr_char_q <= '0;
            wr_fg_q   <= '0;
            wr_bg_q   <= '0;
        end else begin
            state_q   <= state_d;
            fg_q      <= fg_d;
            bg_q      <= bg_d;
            wr_en_q   <= wr_en_d;
            wr_col_q  <= wr_col_d;
            wr_row_q  <= wr_row_d;
            wr_char_q <= wr_char_d;
            wr_fg_q   <= wr_fg_d;
            wr_bg_q   <= wr_bg_d;
        end
    end

    assign in_ready = (state_q != CLEAR);
    assign busy     = (state_q == CLEAR);
    assign wr_en    = wr_en_q;
    assign wr_col   = wr_col_q;
    assign wr_row   = wr_row_q;
    assign wr_char  = wr_char_q;
    assign wr_fg    = wr_fg_q;
    assign wr_bg    = wr_bg_q;

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: reference model queues expected cell writes, a monitor checks them.
module tb_text_writer;

    localparam int NCOL  = 10;
    localparam int NROW  = 5;
    localparam int CELLS = NCOL * NROW;

    typedef struct packed {
        logic [3:0] col;
        logic [2:0] row;
        logic [7:0] ch;
        logic [3:0] fg;
        logic [3:0] bg;
    } wr_t;

    logic       clk_pix = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       wr_en;
    logic [3:0] wr_col;
    logic [2:0] wr_row;
    logic [7:0] wr_char;
    logic [3:0] wr_fg;
    logic [3:0] wr_bg;
    logic [3:0] cur_col;
    logic [2:0] cur_row;
    logic       busy;

    text_writer #(
        .GRID_ROW    (NROW),
        .GRID_COL    (NCOL),
        .ASCII_WIDTH (8),
        .COLOR_WIDTH (4),
        .DEFAULT_FG  (4'hF),
        .DEFAULT_BG  (4'h0)
    ) dut (
        .clk_pix  (clk_pix),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_col   (wr_col),
        .wr_row   (wr_row),
        .wr_char  (wr_char),
        .wr_fg    (wr_fg),
        .wr_bg    (wr_bg),
        .cur_col  (cur_col),
        .cur_row  (cur_row),
        .busy     (busy)
    );

    always #5 clk_pix = ~clk_pix;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  n_wr = 0;
    int  run_len = 0;
    int  last_wr_cyc = -10;
    wr_t sb[$];

    // Reference model: cursor as linear cell index arithmetic, colours, pending-escape flag.
    int m_col, m_row, m_fg, m_bg;
    bit m_esc;

    always @(posedge clk_pix) cyc++;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_col = 0; m_row = 0; m_fg = 15; m_bg = 0; m_esc = 0;
    endtask

    task automatic push_wr(input int c, input int r, input logic [7:0] ch);
        wr_t e;
        e.col = 4'(c); e.row = 3'(r); e.ch = ch; e.fg = 4'(m_fg); e.bg = 4'(m_bg);
        sb.push_back(e);
    endtask

    task automatic model_accept(input logic [7:0] b);
        int pos;
        if (m_esc) begin
            m_bg  = int'(b[7:4]);
            m_fg  = int'(b[3:0]);
            m_esc = 0;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(m_col, m_row, b);
            pos   = (m_row * NCOL + m_col + 1) % CELLS;
            m_col = pos % NCOL;
            m_row = pos / NCOL;
        end else if (b == 8'h0D) begin
            m_col = 0;
        end else if (b == 8'h0A) begin
            m_row = (m_row + 1) % NROW;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_col, m_row, 8'h20);
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < CELLS; i++) push_wr(i % NCOL, i / NCOL, 8'h20);
            m_col = 0; m_row = 0;
        end else if (b == 8'h1B) begin
            m_esc = 1;
        end
    endtask

    // Monitor: every DUT write must match the oldest expected write.
    always @(negedge clk_pix) begin
        if (rst_n && wr_en) begin
            wr_t got, exp;
            got.col = wr_col; got.row = wr_row; got.ch = wr_char; got.fg = wr_fg; got.bg = wr_bg;
            n_wr++;
            run_len     = (cyc == last_wr_cyc + 1) ? run_len + 1 : 1;
            last_wr_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got col=%0d row=%0d ch=%h fg=%h bg=%h, none expected",
                         got.col, got.row, got.ch, got.fg, got.bg);
            end else begin
                exp = sb.pop_front();
                if (got !== exp) begin
                    errors++;
                    $display("FAIL write_fields: got col=%0d row=%0d ch=%h fg=%h bg=%h expected col=%0d row=%0d ch=%h fg=%h bg=%h",
                             got.col, got.row, got.ch, got.fg, got.bg,
                             exp.col, exp.row, exp.ch, exp.fg, exp.bg);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int w = 0;
        @(negedge clk_pix);
        while (!in_ready && w < 200) begin
            @(negedge clk_pix);
            w++;
        end
        if (!in_ready) begin
            chk("send_ready_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            model_accept(b);
            @(posedge clk_pix);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk_pix);
        in_valid = 1'b0;
        in_data  = 8'(($urandom));
        repeat (n) @(posedge clk_pix);
    endtask

    task automatic check_cursor(input string name);
        int w = 0;
        @(negedge clk_pix);
        in_valid = 1'b0;
        while (!in_ready && w < 200) begin
            @(negedge clk_pix);
            w++;
        end
        chk({name, "_ready"}, int'(in_ready), 1);
        chk({name, "_col"}, int'(cur_col), m_col);
        chk({name, "_row"}, int'(cur_row), m_row);
    endtask

    task automatic do_reset();
        @(negedge clk_pix);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        sb.delete();
        repeat (2) @(negedge clk_pix);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_wr_en"},    int'(wr_en), 0);
        chk({tag, "_wr_col"},   int'(wr_col), 0);
        chk({tag, "_wr_row"},   int'(wr_row), 0);
        chk({tag, "_wr_char"},  int'(wr_char), 0);
        chk({tag, "_wr_fg"},    int'(wr_fg), 0);
        chk({tag, "_wr_bg"},    int'(wr_bg), 0);
        chk({tag, "_cur_col"},  int'(cur_col), 0);
        chk({tag, "_cur_row"},  int'(cur_row), 0);
        chk({tag, "_busy"},     int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, cnt, target;
        int r;
        model_reset();
        #1;
        chk_reset_outputs("reset");
        repeat (2) @(negedge clk_pix);
        rst_n = 1'b1;

        // "AB" from home position.
        send_byte("A");
        send_byte("B");
        idle(2);
        check_cursor("ab_cursor");
        chk("ab_cur_col_const", int'(cur_col), 2);

        // 50 back-to-back printables wrap the whole grid.
        do_reset();
        for (int i = 0; i < CELLS; i++) send_byte("a");
        idle(2);
        chk("burst_no_bubble_run", run_len, CELLS);
        check_cursor("burst_cursor");
        chk("burst_wrap_col", int'(cur_col), 0);
        chk("burst_wrap_row", int'(cur_row), 0);

        // CR, LF from (3,2) produce no writes.
        do_reset();
        for (int i = 0; i < 23; i++) send_byte(8'(8'h30 + i));
        idle(1);
        base = n_wr;
        send_byte(8'h0D);
        send_byte(8'h0A);
        idle(3);
        check_cursor("crlf_cursor");
        chk("crlf_col_const", int'(cur_col), 0);
        chk("crlf_row_const", int'(cur_row), 3);
        chk("crlf_no_write", n_wr - base, 0);

        // Backspace inside a line, then at column 0.
        do_reset();
        for (int i = 0; i < 14; i++) send_byte("k");
        send_byte(8'h08);
        idle(2);
        check_cursor("bs_cursor");
        chk("bs_col_const", int'(cur_col), 3);
        send_byte(8'h0D);
        idle(2);
        base = n_wr;
        send_byte(8'h08);
        idle(3);
        check_cursor("bs0_cursor");
        chk("bs0_no_write", n_wr - base, 0);

        // Colour escape takes effect on the immediately following byte.
        do_reset();
        base = n_wr;
        send_byte(8'h1B);
        send_byte(8'h2A);
        send_byte("x");
        idle(3);
        chk("esc_one_write", n_wr - base, 1);

        // Screen clear from (7,3).
        do_reset();
        for (int i = 0; i < 37; i++) send_byte("z");
        idle(1);
        check_cursor("pre_ff_cursor");
        send_byte(8'h0C);
        cnt = 0;
        for (int w = 0; w < 100; w++) begin
            @(negedge clk_pix);
            in_valid = 1'b0;
            if (!in_ready && busy) cnt++;
            else break;
        end
        chk("ff_ready_low_cycles", cnt, CELLS);
        check_cursor("ff_cursor");
        chk("ff_all_written", sb.size(), 0);

        // Reset while in ESC discards the pending colour byte.
        do_reset();
        send_byte(8'h1B);
        do_reset();
        send_byte("y");
        idle(2);
        check_cursor("esc_rst_cursor");

        // Reset at the 20th clear write aborts the sweep.
        do_reset();
        for (int i = 0; i < 37; i++) send_byte("q");
        idle(1);
        check_cursor("pre_ff2_cursor");
        base = n_wr;
        send_byte(8'h0C);
        target = base + 20;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk_pix);
            in_valid = 1'b0;
            #1;
            if (n_wr >= target) break;
        end
        chk("midclear_reached_20", n_wr - base, 20);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midclear_rst");
        sb.delete();
        model_reset();
        repeat (3) begin
            @(negedge clk_pix);
            chk("midclear_hold_wr_en", int'(wr_en), 0);
        end
        rst_n = 1'b1;
        idle(5);
        chk("midclear_no_more_writes", n_wr - base, 20);
        check_cursor("midclear_cursor");

        // Randomized mix of printables, controls, escapes and clears.
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      send_byte(8'($urandom_range(32, 126)));
            else if (r < 76) send_byte(8'h0D);
            else if (r < 82) send_byte(8'h0A);
            else if (r < 88) send_byte(8'h08);
            else if (r < 93) begin
                send_byte(8'h1B);
                send_byte(8'($urandom_range(0, 255)));
            end
            else if (r < 95) send_byte(8'h0C);
            else begin
                case ($urandom_range(0, 5))
                    0: send_byte(8'h00);
                    1: send_byte(8'h07);
                    2: send_byte(8'h7F);
                    3: send_byte(8'h80);
                    4: send_byte(8'hFF);
                    default: send_byte(8'h1F);
                endcase
            end
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (k % 25 == 24) check_cursor("rand_cursor");
        end
        idle(2);
        check_cursor("rand_final_cursor");
        idle(2);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
